// File: rtl/sar_search_signed.sv
// sar_search_signed
//   Successive-approximation driver for an external signed "x < probe"
//   comparator. It recovers an unknown N-bit two's-complement value x in N
//   comparison rounds. The search runs in offset binary (u = x ^ MSB), which
//   makes signed order equal to unsigned order, so the sign bit needs no
//   special case. Probes are formed by OR/XOR only, so nothing can overflow.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   start        in   begins a search when sampled in S_IDLE; ignored otherwise
//   busy         out  high while probing or waiting for a verdict
//   done         out  one-cycle pulse; result is valid on that cycle
//   result       out  N-bit signed recovered value; held until the next search
//   cmp_b        out  N-bit signed probe operand for the responder
//   cmp_req      out  one-cycle pulse: a new probe is on cmp_b
//   cmp_lt       in   verdict: 1 when x < cmp_b (signed)
//   cmp_lt_valid in   cmp_lt is meaningful this cycle
//
// Probe handshake: cmp_req pulses for exactly one cycle when a new cmp_b is
// presented. cmp_b then stays stable until a verdict is taken. The responder
// answers by raising cmp_lt_valid with cmp_lt on any later cycle (as early as
// the cycle right after cmp_req). Only the first cmp_lt_valid seen while
// waiting is consumed. cmp_lt_valid at any other time is dropped. There is no
// timeout.
//
// All outputs come straight from flops. busy and cmp_req are loaded from the
// next state, so they line up with the state register. done and result are
// loaded while in S_DONE, so they appear on the cycle after S_DONE.

module sar_search_signed #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] cmp_b,
  output logic         cmp_req,
  input  logic         cmp_lt,
  input  logic         cmp_lt_valid
);

  localparam int BW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
  localparam logic [BW-1:0] TOP = BW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  acc_u, acc_next;
  logic [BW-1:0] bit_idx, bit_next;
  logic [N-1:0]  probe_next;

  always_comb begin
    state_next = state;
    acc_next   = acc_u;
    bit_next   = bit_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_next   = '0;
          bit_next   = TOP;
          state_next = S_PROBE;
        end
      end
      S_PROBE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_lt_valid) begin
          // x >= trial means x's offset-binary value has this bit set.
          if (!cmp_lt) begin
            acc_next = acc_u | (N'(1) << bit_idx);
          end
          if (bit_idx == '0) begin
            state_next = S_DONE;
          end else begin
            bit_next   = bit_idx - BW'(1);
            state_next = S_PROBE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The probe for the round being entered is computed from the next
  // accumulator/bit index, so cmp_b is already valid in the S_PROBE cycle.
  always_comb begin
    probe_next = (acc_next | (N'(1) << bit_next)) ^ MSB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc_u   <= '0;
      bit_idx <= TOP;
      busy    <= 1'b0;
      done    <= 1'b0;
      cmp_req <= 1'b0;
      cmp_b   <= '0;
      result  <= '0;
    end else begin
      state   <= state_next;
      acc_u   <= acc_next;
      bit_idx <= bit_next;
      busy    <= (state_next == S_PROBE) || (state_next == S_WAIT);
      cmp_req <= (state_next == S_PROBE);
      if (state_next == S_PROBE) begin
        cmp_b <= probe_next;
      end
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        result <= acc_u ^ MSB;
      end
    end
  end

endmodule

// File: tb/tb_sar_search_signed.sv
module tb_sar_search_signed;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] cmp_b;
  logic         cmp_req;
  logic         cmp_lt;
  logic         cmp_lt_valid;

  // responder-side and injection-side drivers kept separate
  logic resp_valid = 1'b0, resp_lt = 1'b0;
  logic inj_valid  = 1'b0, inj_lt  = 1'b0;
  assign cmp_lt_valid = resp_valid | inj_valid;
  assign cmp_lt       = resp_valid ? resp_lt : inj_lt;

  sar_search_signed #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .cmp_b        (cmp_b),
    .cmp_req      (cmp_req),
    .cmp_lt       (cmp_lt),
    .cmp_lt_valid (cmp_lt_valid)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // scoreboard queues
  logic [N-1:0] exp_q[$];
  logic [N-1:0] probe_q[$];
  int done_cnt = 0;

  // responder configuration (written by the stimulus process only)
  logic [N-1:0] resp_x    = '0;
  int           lat_cfg   = 0;
  bit           inject_en = 1'b0;

  // responder bookkeeping (written by the responder only)
  bit           pend = 1'b0;
  int           cnt = 0;
  logic [N-1:0] probe_lat = '0;
  int           lt_ones_total = 0;
  int           unstable_total = 0;

  // behavioural responder with latency lat_cfg cycles after the first wait cycle
  always @(negedge clk) begin
    if (cmp_req) begin
      pend      = 1'b1;
      cnt       = lat_cfg;
      probe_lat = cmp_b;
      if (inject_en) begin
        resp_valid = 1'b1;
        resp_lt    = 1'($urandom_range(0, 1));
      end else begin
        resp_valid = 1'b0;
      end
    end else if (!busy) begin
      pend       = 1'b0;
      resp_valid = 1'b0;
    end else if (pend) begin
      if (cmp_b !== probe_lat) unstable_total++;
      if (cnt == 0) begin
        resp_valid = 1'b1;
        resp_lt    = ($signed(resp_x) < $signed(cmp_b));
        if (resp_lt) lt_ones_total++;
        pend = 1'b0;
      end else begin
        cnt--;
        resp_valid = 1'b0;
      end
    end else begin
      resp_valid = 1'b0;
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end
    if (cmp_req && probe_q.size() > 0) begin
      chk("probe", {24'd0, cmp_b}, {24'd0, probe_q.pop_front()});
    end
  end

  task automatic run_search(input logic [N-1:0] x, input int lat, input bit inj,
                            input logic [N-1:0] exp_res, input int exp_cyc,
                            input int exp_lt, input int poke_a, input int poke_b);
    int n;
    int d0, l0, u0;
    @(negedge clk);
    resp_x    = x;
    lat_cfg   = lat;
    inject_en = inj;
    d0 = done_cnt;
    l0 = lt_ones_total;
    u0 = unstable_total;
    exp_q.push_back(exp_res);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      start = (n == poke_a || n == poke_b);
      if (done) break;
    end
    start = 1'b0;
    inject_en = 1'b0;
    if (n >= 200) begin
      chk("timeout", 32'd1, 32'd0);
      exp_q.delete();
    end else begin
      chk("latency", n, exp_cyc);
    end
    repeat (3) @(negedge clk);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("single_done", done_cnt - d0, 32'd1);
    chk("cmp_b_stable", unstable_total - u0, 32'd0);
    if (exp_lt >= 0) chk("lt_verdicts", lt_ones_total - l0, exp_lt);
  endtask

  typedef struct {
    logic [N-1:0] x;
    int           lat;
    bit           inj;
    logic [N-1:0] exp_res;
    int           exp_cyc;
    int           exp_lt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] m37;
    int lat;
    int d0;

    vecs[0] = '{8'hDB,  0, 1'b0, 8'hDB, 17,  3};
    vecs[1] = '{8'h80,  0, 1'b0, 8'h80, 17,  8};
    vecs[2] = '{8'h7F,  0, 1'b0, 8'h7F, 17,  0};
    vecs[3] = '{8'h00,  3, 1'b1, 8'h00, 41,  7};
    vecs[4] = '{8'h01,  1, 1'b0, 8'h01, 25, -1};
    vecs[5] = '{8'hFE,  2, 1'b0, 8'hFE, 33, -1};
    vecs[6] = '{8'h40,  4, 1'b0, 8'h40, 49, -1};

    // reset
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_cmp_req", {31'd0, cmp_req}, 32'd0);
    chk("rst_cmp_b",   {24'd0, cmp_b},   32'd0);
    chk("rst_result",  {24'd0, result},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // probe sequence for x = -37
    m37 = 8'hDB;
    probe_q.push_back(8'h00); probe_q.push_back(8'hC0);
    probe_q.push_back(8'hE0); probe_q.push_back(8'hD0);
    probe_q.push_back(8'hD8); probe_q.push_back(8'hDC);
    probe_q.push_back(8'hDA); probe_q.push_back(8'hDB);
    run_search(m37, 0, 1'b0, 8'hDB, 17, 3, -1, -1);
    chk("probe_q_drained", probe_q.size(), 32'd0);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      run_search(vecs[i].x, vecs[i].lat, vecs[i].inj, vecs[i].exp_res,
                 vecs[i].exp_cyc, vecs[i].exp_lt, -1, -1);
    end

    // start pulses while busy are ignored
    run_search(8'h05, 0, 1'b0, 8'h05, 17, -1, 4, 9);

    // asynchronous reset mid-search
    @(negedge clk);
    resp_x  = 8'h25;
    lat_cfg = 1;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",    {31'd0, busy},    32'd0);
    chk("arst_cmp_req", {31'd0, cmp_req}, 32'd0);
    chk("arst_cmp_b",   {24'd0, cmp_b},   32'd0);
    chk("arst_result",  {24'd0, result},  32'd0);
    chk("arst_done",    {31'd0, done},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    inj_valid = 1'b1;
    inj_lt    = 1'b0;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_valid_busy", {31'd0, busy},    32'd0);
    chk("late_valid_req",  {31'd0, cmp_req}, 32'd0);
    chk("aborted_no_done", done_cnt - d0,    32'd0);
    run_search(8'hFF, 0, 1'b0, 8'hFF, 17, -1, -1, -1);

    // sweep all values with random latency
    for (int v = 0; v < 256; v++) begin
      lat = $urandom_range(0, 4);
      run_search(v[N-1:0], lat, 1'b0, v[N-1:0], 1 + N * (2 + lat), -1, -1, -1);
    end

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
